// File: rtl/des_key_sched_pkg.sv
// Shared DES key-schedule constants: widths, per-round shift table, state encoding,
// PC-1/PC-2 selection tables and the 28-bit half rotator.
package des_key_sched_pkg;

  localparam int KEY_W  = 64;
  localparam int CD_W   = 56;
  localparam int SK_W   = 48;
  localparam int HALF_W = 28;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Left-shift amount for rounds 1..16, stored at index 0..15.
  localparam logic [1:0] SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Source key bit (1 = MSB) for each CD bit 1..56.
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // Source CD bit (1 = MSB) for each subkey bit 1..48.
  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // "Left" moves bits toward bit 1, matching the DES definition of the shift.
  function automatic logic [1:HALF_W] rot_half(input logic [1:HALF_W] h,
                                               input logic left,
                                               input logic [1:0] amt);
    logic [1:HALF_W] r;
    if (left) begin
      if (amt == 2'd2) r = {h[3:HALF_W], h[1:2]};
      else             r = {h[2:HALF_W], h[1]};
    end else begin
      if (amt == 2'd2) r = {h[HALF_W-1:HALF_W], h[1:HALF_W-2]};
      else             r = {h[HALF_W], h[1:HALF_W-1]};
    end
    return r;
  endfunction

  function automatic logic [1:CD_W] rot_cd(input logic [1:CD_W] cd,
                                           input logic left,
                                           input logic [1:0] amt);
    return {rot_half(cd[1:HALF_W], left, amt), rot_half(cd[HALF_W+1:CD_W], left, amt)};
  endfunction

endpackage

// File: rtl/key_perm1.sv
// PC-1: selects the 56 key bits into C0/D0 and drops the eight parity bits.
module key_perm1
  import des_key_sched_pkg::*;
(
  input  logic [1:KEY_W] key,
  output logic [1:CD_W]  cd
);

  logic [7:0] parity_unused;

  generate
    for (genvar gi = 0; gi < CD_W; gi++) begin : g_pc1
      localparam int SRC = PC1_TAB[gi];
      assign cd[gi+1] = key[SRC];
    end
    for (genvar gi = 0; gi < 8; gi++) begin : g_parity
      assign parity_unused[gi] = key[8*(gi+1)];
    end
  endgenerate

endmodule

// File: rtl/key_perm2.sv
// PC-2: compresses the 56-bit C/D register into a 48-bit round subkey.
module key_perm2
  import des_key_sched_pkg::*;
(
  input  logic [1:CD_W] cd,
  output logic [1:SK_W] sk
);

  // Eight C/D bits never reach the subkey.
  logic [7:0] dropped_unused;
  assign dropped_unused = {cd[9], cd[18], cd[22], cd[25], cd[35], cd[38], cd[43], cd[54]};

  generate
    for (genvar gi = 0; gi < SK_W; gi++) begin : g_pc2
      localparam int SRC = PC2_TAB[gi];
      assign sk[gi+1] = cd[SRC];
    end
  endgenerate

endmodule

// File: rtl/des_key_sched.sv
// DES key-schedule sequencer: PC-1 once, then steps C/D and streams 16 PC-2 subkeys
// over valid/ready, forward (K1..K16) or reverse (K16..K1) via right rotations.
module des_key_sched
  import des_key_sched_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            decrypt,
  input  logic [1:KEY_W]  key,
  input  logic            abort,
  input  logic            sk_ready,
  output logic [1:SK_W]   sk,
  output logic            sk_valid,
  output logic [3:0]      sk_round,
  output logic            busy,
  output logic            done
);

  state_t         state_reg, state_next;
  logic [1:CD_W]  cd_reg, cd_next;
  logic [3:0]     step_reg, step_next;
  logic           mode_reg, mode_next;
  logic           done_reg, done_next;
  logic [1:CD_W]  pc1_cd;

  key_perm1 u_pc1 (
    .key (key),
    .cd  (pc1_cd)
  );

  key_perm2 u_pc2 (
    .cd (cd_reg),
    .sk (sk)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cd_reg    <= '0;
      step_reg  <= '0;
      mode_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cd_reg    <= cd_next;
      step_reg  <= step_next;
      mode_reg  <= mode_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cd_next    = cd_reg;
    step_next  = step_reg;
    mode_next  = mode_reg;
    done_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          mode_next  = decrypt;
          step_next  = 4'd0;
          state_next = ST_RUN;
          // Decrypt starts from C16D16, which equals C0D0 after the full 28-bit cycle.
          cd_next    = decrypt ? pc1_cd : rot_cd(pc1_cd, 1'b1, SHIFT[0]);
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (sk_ready) begin
          if (step_reg == 4'd15) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end else begin
            step_next = step_reg + 4'd1;
            if (mode_reg) cd_next = rot_cd(cd_reg, 1'b0, SHIFT[4'd15 - step_reg]);
            else          cd_next = rot_cd(cd_reg, 1'b1, SHIFT[step_reg + 4'd1]);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign sk_valid = (state_reg == ST_RUN);
  assign busy     = (state_reg == ST_RUN);
  assign done     = done_reg;
  assign sk_round = mode_reg ? (4'd15 - step_reg) : step_reg;

endmodule

// File: tb/tb_des_key_sched.sv
// Self-checking bench for des_key_sched: known vectors, random keys/backpressure against
// a cumulative-shift reference model, plus start-while-busy, abort, reset and parity cases.
module tb_des_key_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        decrypt;
  logic [1:64] key;
  logic        abort;
  logic        sk_ready;
  logic [1:48] sk;
  logic        sk_valid;
  logic [3:0]  sk_round;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  des_key_sched dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .decrypt  (decrypt),
    .key      (key),
    .abort    (abort),
    .sk_ready (sk_ready),
    .sk       (sk),
    .sk_valid (sk_valid),
    .sk_round (sk_round),
    .busy     (busy),
    .done     (done)
  );

  localparam int PC1_T [56] = '{
    57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
    63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{
    14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int SH_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  // Bit n (1 = MSB) of a width-bit value.
  function automatic logic [63:0] getbit(input logic [63:0] v, input int width, input int n);
    return (v >> (width - n)) & 64'd1;
  endfunction

  // Subkey of round r (1..16): C_r/D_r are C0/D0 rotated by the cumulative shift total.
  function automatic logic [47:0] model_sk(input logic [63:0] k, input int r);
    logic [63:0] cd0, c0, d0, cr, dr, cdr, res;
    int s;
    s = 0;
    for (int i = 0; i < r; i++) s += SH_T[i];
    cd0 = 64'd0;
    for (int i = 0; i < 56; i++) cd0 = (cd0 << 1) | getbit(k, 64, PC1_T[i]);
    c0 = (cd0 >> 28) & 64'hFFFFFFF;
    d0 = cd0 & 64'hFFFFFFF;
    cr = 64'd0;
    dr = 64'd0;
    for (int p = 1; p <= 28; p++) begin
      cr = (cr << 1) | getbit(c0, 28, ((p - 1 + s) % 28) + 1);
      dr = (dr << 1) | getbit(d0, 28, ((p - 1 + s) % 28) + 1);
    end
    cdr = (cr << 28) | dr;
    res = 64'd0;
    for (int j = 0; j < 48; j++) res = (res << 1) | getbit(cdr, 56, PC2_T[j]);
    return res[47:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [47:0] got [16];
  logic [3:0]  got_round [16];
  logic [47:0] ref_stream [16];

  // Starts a schedule and consumes it; optional disturbances at a given presentation index.
  task automatic run_sched(input logic [63:0] k, input logic dec, input int pct,
                           input int busy_at, input logic [63:0] busy_key,
                           input int abort_at, input int rst_at);
    int idx, cyc, e_round;
    bit stopped, busy_done;
    @(negedge clk);
    key = k; decrypt = dec; start = 1'b1; abort = 1'b0; sk_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    idx = 0; cyc = 0; stopped = 1'b0; busy_done = 1'b0;
    while (idx < 16 && !stopped && cyc < 400) begin
      e_round = dec ? 16 - idx : idx + 1;
      check("sk_valid", 64'(sk_valid), 64'd1);
      check("busy", 64'(busy), 64'd1);
      check("sk", 64'(sk), 64'(model_sk(k, e_round)));
      check("sk_round", 64'(sk_round), 64'(e_round - 1));
      got[idx] = sk;
      got_round[idx] = sk_round;
      start = 1'b0;
      abort = 1'b0;
      if (idx == busy_at && !busy_done) begin
        start = 1'b1; key = busy_key; decrypt = ~dec; busy_done = 1'b1;
      end
      if (idx == abort_at) begin
        abort = 1'b1; sk_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0; sk_ready = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(sk_valid), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        @(negedge clk);
        check("abort_done_next", 64'(done), 64'd0);
        stopped = 1'b1;
      end else if (idx == rst_at) begin
        sk_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_valid", 64'(sk_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sk", 64'(sk), 64'd0);
        check("rst_round", 64'(sk_round), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        stopped = 1'b1;
      end else begin
        sk_ready = (pct >= 100) || ($urandom_range(0, 99) < pct);
        @(negedge clk);
        if (sk_ready) idx++;
      end
      cyc++;
    end
    start = 1'b0;
    if (!stopped) begin
      if (idx < 16) begin
        checks++; errors++;
        $display("FAIL timeout: got %0d handshakes expected 16", idx);
      end else begin
        check("done_pulse", 64'(done), 64'd1);
        check("done_busy", 64'(busy), 64'd0);
        check("done_valid", 64'(sk_valid), 64'd0);
        if (pct >= 100 && busy_at < 0) check("latency", 64'(cyc), 64'd16);
        sk_ready = 1'b0;
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
      end
    end
    sk_ready = 1'b0;
    $display("schedule key=%h dec=%0d ready%%=%0d handshakes=%0d", k, dec, pct, idx);
  endtask

  typedef struct {
    logic [63:0] key;
    logic        dec;
    int          pct;
    logic [47:0] first;
    logic [3:0]  first_round;
    logic [47:0] last;
    logic [3:0]  last_round;
  } vec_t;

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_P = 64'h123456789ABCDEF0;

  initial begin
    vec_t vecs [3];
    logic [63:0] rk;
    logic [47:0] par_stream [16];

    vecs[0] = '{KEY_A, 1'b0, 100, 48'h1B02EFFC7072, 4'd0,  48'hCB3D8B0E17F5, 4'd15};
    vecs[1] = '{KEY_A, 1'b1, 100, 48'hCB3D8B0E17F5, 4'd15, 48'h1B02EFFC7072, 4'd0};
    vecs[2] = '{KEY_A, 1'b0, 50,  48'h1B02EFFC7072, 4'd0,  48'hCB3D8B0E17F5, 4'd15};

    rst = 1'b1; start = 1'b0; decrypt = 1'b0; key = '0; abort = 1'b0; sk_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_valid", 64'(sk_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_sk", 64'(sk), 64'd0);
    check("reset_round", 64'(sk_round), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    // abort while idle must be harmless
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("idle_abort_busy", 64'(busy), 64'd0);

    for (int v = 0; v < 3; v++) begin
      run_sched(vecs[v].key, vecs[v].dec, vecs[v].pct, -1, 64'd0, -1, -1);
      check("vec_first", 64'(got[0]), 64'(vecs[v].first));
      check("vec_first_round", 64'(got_round[0]), 64'(vecs[v].first_round));
      check("vec_last", 64'(got[15]), 64'(vecs[v].last));
      check("vec_last_round", 64'(got_round[15]), 64'(vecs[v].last_round));
      if (v == 0) begin
        for (int i = 0; i < 16; i++) ref_stream[i] = got[i];
      end else begin
        for (int i = 0; i < 16; i++)
          check(vecs[v].dec ? "reverse_stream" : "bp_stream", 64'(got[i]),
                64'(vecs[v].dec ? ref_stream[15 - i] : ref_stream[i]));
      end
    end

    for (int r = 0; r < 6; r++) begin
      rk = {$urandom(), $urandom()};
      run_sched(rk, 1'($urandom_range(0, 1)), 30 + 10 * r, -1, 64'd0, -1, -1);
    end

    run_sched(KEY_A, 1'b0, 100, 5, KEY_P, -1, -1);
    for (int i = 0; i < 16; i++) check("busy_start_stream", 64'(got[i]), 64'(ref_stream[i]));

    run_sched(KEY_A, 1'b0, 100, -1, 64'd0, 8, -1);
    run_sched(KEY_A, 1'b1, 70, -1, 64'd0, -1, -1);

    run_sched(KEY_A, 1'b0, 100, -1, 64'd0, -1, 10);
    run_sched(KEY_A, 1'b0, 100, -1, 64'd0, -1, -1);
    check("restart_k1", 64'(got[0]), 64'h1B02EFFC7072);

    run_sched(KEY_P, 1'b0, 100, -1, 64'd0, -1, -1);
    for (int i = 0; i < 16; i++) par_stream[i] = got[i];
    run_sched(KEY_P ^ 64'h0101010101010101, 1'b0, 60, -1, 64'd0, -1, -1);
    for (int i = 0; i < 16; i++) check("parity_stream", 64'(got[i]), 64'(par_stream[i]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
